cfu_issue: RTL and testbench

- Issue/sequencing stage directly upstream of the cfu core, inside the CPU execute stage.
- Detects custom-0 instructions and latches rd, funct3/funct7 and both operands.
- Holds the operands stable on the core-side ports for a fixed LATENCY cycles, then captures the core result.
- Stalls the CPU pipeline while busy and presents one registered result plus rd to writeback; supports flush and downstream freeze.

---
 rtl/cfu_issue_pkg.sv | 14 +
 rtl/cfu_issue.sv | 135 +++++++++++++
 tb/tb_cfu_issue.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cfu_issue_pkg.sv
// Shared constants and types for the cfu_issue sequencing stage.
package cfu_issue_pkg;

    localparam logic [6:0]  CUSTOM0        = 7'b0001011;
    localparam int unsigned XLEN_DEF       = 32;
    localparam int unsigned CTRL_WIDTH_DEF = 10;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/cfu_issue.sv
// Issue stage in front of the cfu core: accepts custom-0 ops, holds operands for LATENCY
// cycles, registers the result for writeback. Optional perf counters: CFU_ISSUE_PERF_EN.
module cfu_issue
    import cfu_issue_pkg::*;
#(
    parameter int unsigned XLEN       = XLEN_DEF,
    parameter int unsigned CTRL_WIDTH = CTRL_WIDTH_DEF,
    parameter int unsigned LATENCY    = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic                  valid_i,
    input  logic [31:0]           instr_i,
    input  logic [XLEN-1:0]       src1_i,
    input  logic [XLEN-1:0]       src2_i,
    output logic                  busy_o,
    output logic                  cfu_valid_o,
    output logic [CTRL_WIDTH-1:0] cfu_ctrl_o,
    output logic [XLEN-1:0]       cfu_src1_o,
    output logic [XLEN-1:0]       cfu_src2_o,
    input  logic [XLEN-1:0]       cfu_rslt_i,
    output logic                  rslt_valid_o,
    output logic [XLEN-1:0]       rslt_o,
    output logic [4:0]            rd_o
`ifdef CFU_ISSUE_PERF_EN
    ,
    output logic [31:0]           perf_ops_o,
    output logic [31:0]           perf_busy_o
`endif
);

    localparam logic [3:0] CntInit = 4'(LATENCY - 1);

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [CTRL_WIDTH-1:0] ctrl_q;
    logic [XLEN-1:0]       src1_q, src2_q, rslt_q;
    logic [4:0]            rd_q;
    logic                  is_cfu, accept, capture;

    assign is_cfu  = valid_i & (instr_i[6:0] == CUSTOM0);
    assign accept  = is_cfu & ~flush_i & ~stall_i & (state_q == StIdle);
    assign capture = (state_q == StExec) & ~flush_i & (cnt_q == 4'd0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StExec;
                    cnt_d   = CntInit;
                end
            end
            StExec: begin
                if (flush_i) begin
                    state_d = StIdle;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd0) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StDone: begin
                if (flush_i || !stall_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ctrl_q <= '0;
            src1_q <= '0;
            src2_q <= '0;
            rd_q   <= '0;
            rslt_q <= '0;
        end else begin
            if (accept) begin
                ctrl_q <= CTRL_WIDTH'({instr_i[31:25], instr_i[14:12]});
                src1_q <= src1_i;
                src2_q <= src2_i;
                rd_q   <= instr_i[11:7];
            end
            if (capture) begin
                rslt_q <= cfu_rslt_i;
            end
        end
    end

    // Reset gates the combinational accept term so every output reads 0 while in reset.
    assign busy_o       = (accept & rst_i) | (state_q == StExec);
    assign cfu_valid_o  = (state_q == StExec);
    assign rslt_valid_o = (state_q == StDone) & ~flush_i;
    assign cfu_ctrl_o   = ctrl_q;
    assign cfu_src1_o   = src1_q;
    assign cfu_src2_o   = src2_q;
    assign rslt_o       = rslt_q;
    assign rd_o         = rd_q;

`ifdef CFU_ISSUE_PERF_EN
    generate
        logic [31:0] perf_ops_q, perf_busy_q;

        always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) begin
                perf_ops_q  <= 32'd0;
                perf_busy_q <= 32'd0;
            end else begin
                if (capture) perf_ops_q  <= perf_ops_q + 32'd1;
                if (busy_o)  perf_busy_q <= perf_busy_q + 32'd1;
            end
        end

        assign perf_ops_o  = perf_ops_q;
        assign perf_busy_o = perf_busy_q;
    endgenerate
`endif

endmodule

// File: tb/tb_cfu_issue.sv
// Bench for cfu_issue: three instances (LATENCY 1,2,3) share stimulus; a cycle-age model checks
// all outputs at every falling edge. Perf checks compile in with CFU_ISSUE_PERF_EN.
module tb_cfu_issue;

    localparam int N = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        valid = 1'b0;
    logic [31:0] instr = 32'd0;
    logic [31:0] src1 = 32'd0;
    logic [31:0] src2 = 32'd0;

    logic        busy_w   [N];
    logic        cvalid_w [N];
    logic [9:0]  ctrl_w   [N];
    logic [31:0] csrc1_w  [N];
    logic [31:0] csrc2_w  [N];
    logic [31:0] crslt_w  [N];
    logic        rvalid_w [N];
    logic [31:0] rslt_w   [N];
    logic [4:0]  rd_w     [N];
`ifdef CFU_ISSUE_PERF_EN
    logic [31:0] pops_w   [N];
    logic [31:0] pbusy_w  [N];
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] core_f(input logic [9:0] c, input logic [31:0] a,
                                           input logic [31:0] b);
        case (c[2:0])
            3'd1:    return a + b;
            3'd2:    return a - b;
            default: return a ^ b;
        endcase
    endfunction

    function automatic logic [31:0] mk(input int f3, input int rd);
        logic [31:0] w;
        w = {7'd0, 5'd0, 5'd0, 3'(f3), 5'(rd), 7'b0001011};
        return w;
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[lat%0d] got=%h exp=%h t=%0t", name, k + 1, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < N; g++) begin : g_dut
        int vcnt;

        cfu_issue #(
            .XLEN      (32),
            .CTRL_WIDTH(10),
            .LATENCY   (g + 1)
        ) u_dut (
            .clk_i       (clk),
            .rst_i       (rst_n),
            .stall_i     (stall),
            .flush_i     (flush),
            .valid_i     (valid),
            .instr_i     (instr),
            .src1_i      (src1),
            .src2_i      (src2),
            .busy_o      (busy_w[g]),
            .cfu_valid_o (cvalid_w[g]),
            .cfu_ctrl_o  (ctrl_w[g]),
            .cfu_src1_o  (csrc1_w[g]),
            .cfu_src2_o  (csrc2_w[g]),
            .cfu_rslt_i  (crslt_w[g]),
            .rslt_valid_o(rvalid_w[g]),
            .rslt_o      (rslt_w[g]),
            .rd_o        (rd_w[g])
`ifdef CFU_ISSUE_PERF_EN
            ,
            .perf_ops_o  (pops_w[g]),
            .perf_busy_o (pbusy_w[g])
`endif
        );

        // Core stub: the result is only correct in the last cycle of the operand window.
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) vcnt <= 0;
            else        vcnt <= cvalid_w[g] ? vcnt + 1 : 0;
        end
        assign crslt_w[g] = (cvalid_w[g] && vcnt == g) ?
                            core_f(ctrl_w[g], csrc1_w[g], csrc2_w[g]) : 32'hDEADBEEF;
    end

    // Model: age counts cycles since accept; ages 1..L are execute, beyond L is result-ready.
    logic        m_act  [N];
    int          m_age  [N];
    logic [9:0]  m_ctrl [N];
    logic [31:0] m_s1   [N];
    logic [31:0] m_s2   [N];
    logic [31:0] m_rslt [N];
    logic [4:0]  m_rd   [N];
    int          m_ops  [N];
    int          m_busy [N];

    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            int  lat;
            logic is_cfu, acc, e_exec, e_done, e_busy;
            lat = k + 1;
            if (!rst_n) begin
                m_act[k] = 1'b0; m_age[k] = 0; m_ctrl[k] = '0; m_s1[k] = '0; m_s2[k] = '0;
                m_rslt[k] = '0; m_rd[k] = '0; m_ops[k] = 0; m_busy[k] = 0;
            end
            is_cfu = valid && (instr[6:0] == 7'b0001011);
            acc    = rst_n && !m_act[k] && is_cfu && !flush && !stall;
            e_exec = m_act[k] && m_age[k] >= 1 && m_age[k] <= lat;
            e_done = m_act[k] && m_age[k] > lat;
            e_busy = acc || e_exec;

            chk("busy", k, 32'(busy_w[k]), 32'(e_busy));
            chk("cfu_valid", k, 32'(cvalid_w[k]), 32'(e_exec));
            chk("rslt_valid", k, 32'(rvalid_w[k]), 32'(e_done && !flush));
            chk("ctrl", k, 32'(ctrl_w[k]), 32'(m_ctrl[k]));
            chk("src1", k, csrc1_w[k], m_s1[k]);
            chk("src2", k, csrc2_w[k], m_s2[k]);
            chk("rslt", k, rslt_w[k], m_rslt[k]);
            chk("rd", k, 32'(rd_w[k]), 32'(m_rd[k]));
`ifdef CFU_ISSUE_PERF_EN
            chk("perf_ops", k, pops_w[k], 32'(m_ops[k]));
            chk("perf_busy", k, pbusy_w[k], 32'(m_busy[k]));
`endif

            if (rst_n) begin
                if (e_busy) m_busy[k]++;
                if (!m_act[k]) begin
                    if (acc) begin
                        m_act[k]  = 1'b1;
                        m_age[k]  = 1;
                        m_ctrl[k] = {instr[31:25], instr[14:12]};
                        m_s1[k]   = src1;
                        m_s2[k]   = src2;
                        m_rd[k]   = instr[11:7];
                    end
                end else if (flush) begin
                    m_act[k] = 1'b0;
                end else if (m_age[k] < lat) begin
                    m_age[k]++;
                end else if (m_age[k] == lat) begin
                    m_age[k]++;
                    m_rslt[k] = core_f(m_ctrl[k], m_s1[k], m_s2[k]);
                    m_ops[k]++;
                end else if (!stall) begin
                    m_act[k] = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Returns in the first execute cycle (one cycle after the accept cycle).
    task automatic issue(input logic [31:0] w, input logic [31:0] a, input logic [31:0] b);
        valid = 1'b1;
        instr = w;
        src1  = a;
        src2  = b;
        tick();
        valid = 1'b0;
    endtask

    initial begin
        int cnt;
        wait_n(3);
        chk("reset_rslt", 0, rslt_w[0], 32'd0);
        chk("reset_busy", 2, 32'(busy_w[2]), 32'd0);
        rst_n = 1'b1;

        // add, rd=5: 7+3
        issue(mk(1, 5), 32'd7, 32'd3);
        wait_n(5);
        chk("add_rslt", 0, rslt_w[0], 32'd10);
        chk("add_rd", 0, 32'(rd_w[0]), 32'd5);

        // sub: 5-9, count operand-valid cycles on the 3-cycle instance
        issue(mk(2, 9), 32'd5, 32'd9);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (cvalid_w[2]) begin
                cnt++;
                chk("sub_src1_hold", 2, csrc1_w[2], 32'd5);
            end
            tick();
        end
        chk("sub_valid_cycles", 2, 32'(cnt), 32'd3);
        chk("sub_rslt", 2, rslt_w[2], 32'hFFFFFFFC);

        // xor held under stall in the result-ready state
        issue(mk(0, 12), 32'h0000F0F0, 32'h00000FF0);
        stall = 1'b1;
        cnt = 0;
        for (int i = 0; i < 7; i++) begin
            if (rvalid_w[2]) cnt++;
            tick();
        end
        stall = 1'b0;
        chk("stall_hold_cycles", 2, 32'(cnt), 32'd4);
        chk("stall_rslt", 2, rslt_w[2], 32'h0000FF00);
        chk("stall_release_valid", 2, 32'(rvalid_w[2]), 32'd1);
        tick();
        chk("stall_after_valid", 2, 32'(rvalid_w[2]), 32'd0);
        wait_n(2);

        // flush in second execute cycle, then a normal op
        issue(mk(1, 7), 32'd1, 32'd2);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_n(5);
        chk("flush_rslt_kept", 2, rslt_w[2], 32'h0000FF00);
        issue(mk(1, 8), 32'd100, 32'd23);
        wait_n(5);
        chk("post_flush_rslt", 2, rslt_w[2], 32'd123);
        chk("post_flush_rd", 2, 32'(rd_w[2]), 32'd8);

        // asynchronous reset mid-execute
        issue(mk(2, 4), 32'd9, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < N; k++) begin
            chk("async_busy", k, 32'(busy_w[k]), 32'd0);
            chk("async_cvalid", k, 32'(cvalid_w[k]), 32'd0);
            chk("async_src1", k, csrc1_w[k], 32'd0);
            chk("async_rslt", k, rslt_w[k], 32'd0);
            chk("async_rd", k, 32'(rd_w[k]), 32'd0);
        end
        wait_n(2);
        rst_n = 1'b1;
        valid = 1'b1;
        instr = {25'd0, 7'b0110011};
        tick();
        chk("noncustom_busy", 0, 32'(busy_w[0]), 32'd0);
        wait_n(2);
        valid = 1'b0;

        // three ops, the middle one flushed in its first execute cycle
        issue(mk(1, 1), 32'd1, 32'd1);
        wait_n(5);
        issue(mk(1, 2), 32'd2, 32'd2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_n(5);
        issue(mk(1, 3), 32'd3, 32'd3);
        wait_n(5);
        chk("perf_seq_rslt", 1, rslt_w[1], 32'd6);
`ifdef CFU_ISSUE_PERF_EN
        chk("perf_ops_lit", 1, pops_w[1], 32'd2);
        chk("perf_busy_lit", 1, pbusy_w[1], 32'd8);
        chk("perf_busy_lit", 0, pbusy_w[0], 32'd6);
        chk("perf_busy_lit", 2, pbusy_w[2], 32'd10);
`endif

        wait_n(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
